max_pool_2x2: RTL

//   Downstream consumer of the conv add-bias/ReLU stage: accepts its post-ReLU float32 stream
//   (one pixel per valid cycle, raster order, no backpressure) and performs 2x2 stride-2 max

---
 rtl/max_pool_2x2_pkg.sv | 14 +
 rtl/max_pool_2x2_pool_line_buf.sv | 26 ++
 rtl/max_pool_2x2.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_pkg.sv
// Shared constants and FSM encoding for the 2x2 max-pool block.
// Stands in for the cnn_defs.vh include: word width, float zero, sign bit, row-phase states.
package max_pool_2x2_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam logic [31:0] FP_ZERO        = 32'h0000_0000;
    localparam int          FP_SIGN_BIT    = 31;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } pool_state_e;

endpackage

// File: rtl/max_pool_2x2_pool_line_buf.sv
// Half-width line buffer holding the horizontal pair maxima of the even row.
// One synchronous write port, one asynchronous read port, no reset.
module pool_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 15,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster float32 stream (non-negative values, no backpressure).
// Optional macro MAXPOOL_RELU_GUARD_EN clamps sign-bit-set inputs to +0.0 before pooling.
module max_pool_2x2
    import max_pool_2x2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_W      = 30,
    parameter int IMG_H      = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    generate
        if ((IMG_W % 2) != 0) begin : g_bad_img_w
            $error("max_pool_2x2: IMG_W must be even");
        end
        if ((IMG_H % 2) != 0) begin : g_bad_img_h
            $error("max_pool_2x2: IMG_H must be even");
        end
    endgenerate

    // Magnitude-only compare is exact ordering for non-negative IEEE floats; ties keep a.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
    endfunction

`ifdef MAXPOOL_RELU_GUARD_EN
    function automatic logic [DATA_WIDTH-1:0] relu_guard(input logic [DATA_WIDTH-1:0] x);
        return x[FP_SIGN_BIT] ? DATA_WIDTH'(FP_ZERO) : x;
    endfunction
`endif

    logic [DATA_WIDTH-1:0] pix;
`ifdef MAXPOOL_RELU_GUARD_EN
    assign pix = relu_guard(data_in);
`else
    assign pix = data_in;
`endif

    pool_state_e           state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic                  lb_we;
    logic [LB_AW-1:0]      lb_addr;
    logic [DATA_WIDTH-1:0] lb_rdata;
    logic [DATA_WIDTH-1:0] pair_max;
    logic                  last_col, last_row;

    assign lb_addr  = LB_AW'(col_q >> 1);
    assign pair_max = fmax(hold_q, pix);
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HALF_W),
        .AW         (LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (valid_in) begin
            if (!col_q[0]) begin
                hold_d = pix;
            end else if (state_q == EVEN_ROW) begin
                lb_we = 1'b1;
            end else begin
                data_out_d   = fmax(lb_rdata, pair_max);
                valid_out_d  = 1'b1;
                frame_done_d = last_row && last_col;
            end

            // Row phase alternates per row; the frame wrap always restarts on an even row.
            if (last_col) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = EVEN_ROW;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EVEN_ROW;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
